// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: sizes, rcon seed, FSM states and byte helpers.
package aes_pkg;

   localparam int AES_NR      = 10;
   localparam int AES_KEY_W   = 128;
   localparam int AES_SCHED_W = 1408;

   localparam logic [7:0] RCON_RESET = 8'h01;

   typedef enum logic [1:0] {IDLE, EXPAND, DONE} schedState_t;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[b];
   endfunction

   // Multiply by x in GF(2^8); also steps rcon through 01,02,...,80,1b,36.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

endpackage

// File: rtl/aes_key_round_step.sv
// One AES-128 key-expansion round: previous round key and rcon in, next round key out.
module aes_key_round_step
   import aes_pkg::*;
(
   input  logic [AES_KEY_W-1:0] prevKey,
   input  logic [7:0]           rcon,
   output logic [AES_KEY_W-1:0] nextKey
);

   logic [31:0] w0, w1, w2, w3;
   logic [31:0] temp;
   logic [31:0] n0, n1, n2, n3;

   assign {w0, w1, w2, w3} = prevKey;

   // RotWord moves the top byte of w3 to the bottom before substitution.
   assign temp = {sbox(w3[23:16]) ^ rcon, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};

   assign n0 = w0 ^ temp;
   assign n1 = w1 ^ n0;
   assign n2 = w2 ^ n1;
   assign n3 = w3 ^ n2;

   assign nextKey = {n0, n1, n2, n3};

endmodule

// File: rtl/aes128_key_schedule_seq.sv
// Iterative AES-128 key expansion producing a registered 11-round-key schedule.
// Optional macro AES_KEY_SCHED_ZEROIZE_EN adds a synchronous zeroize input.
module aes128_key_schedule_seq
   import aes_pkg::*;
#(
   parameter int ROUNDS_PER_CYCLE = 1
)
(
   input  logic                   clk,
   input  logic                   rst_n,
`ifdef AES_KEY_SCHED_ZEROIZE_EN
   input  logic                   zeroize,
`endif
   input  logic [AES_KEY_W-1:0]   key_in,
   input  logic                   key_valid,
   output logic                   key_ready,
   output logic [AES_SCHED_W-1:0] round_keys,
   output logic                   keys_valid
);

   if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2) begin : g_badParam
      $error("ROUNDS_PER_CYCLE must be 1 or 2");
   end

   schedState_t            state, stateNext;
   logic [3:0]             counter;
   logic [7:0]             rcon;
   logic [AES_KEY_W-1:0]   lastKey, stepKey0, stepKey1;
   logic [AES_SCHED_W-1:0] roundKeys;
   logic                   zeroizeReq, acceptKey, lastStep;

`ifdef AES_KEY_SCHED_ZEROIZE_EN
   assign zeroizeReq = zeroize;
`else
   assign zeroizeReq = 1'b0;
`endif

   assign key_ready  = (state != EXPAND) && !zeroizeReq;
   assign acceptKey  = key_ready && key_valid;
   assign lastStep   = (int'(counter) + ROUNDS_PER_CYCLE - 1 == AES_NR);
   assign round_keys = roundKeys;

   aes_key_round_step u_step0 (.prevKey(lastKey), .rcon(rcon), .nextKey(stepKey0));

   if (ROUNDS_PER_CYCLE == 2) begin : g_twoRounds
      aes_key_round_step u_step1 (.prevKey(stepKey0), .rcon(xtime(rcon)), .nextKey(stepKey1));
   end else begin : g_oneRound
      assign stepKey1 = stepKey0;
   end

   // NOTE: every signal assigned here needs a default first, otherwise a latch is inferred.
   always_comb begin
      stateNext = state;
      if (zeroizeReq) begin
         stateNext = IDLE;
      end else begin
         case (state)
            IDLE, DONE: if (key_valid) stateNext = EXPAND;
            EXPAND:     if (lastStep)  stateNext = DONE;
            default:    stateNext = IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         keys_valid <= 1'b0;
      end else begin
         state      <= stateNext;
         keys_valid <= (stateNext == DONE);
      end
   end

   // NOTE: the schedule store is reset too, so an aborted expansion never leaves key material behind.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         roundKeys <= '0;
         lastKey   <= '0;
         counter   <= 4'd0;
         rcon      <= RCON_RESET;
      end else if (zeroizeReq) begin
         roundKeys <= '0;
         lastKey   <= '0;
         counter   <= 4'd0;
         rcon      <= RCON_RESET;
      end else if (acceptKey) begin
         roundKeys <= {key_in, {(AES_SCHED_W - AES_KEY_W){1'b0}}};
         lastKey   <= key_in;
         counter   <= 4'd1;
         rcon      <= RCON_RESET;
      end else if (state == EXPAND) begin
         // Round r lives in slice (10-r); counter names the next round to produce.
         roundKeys[AES_KEY_W*(AES_NR - int'(counter)) +: AES_KEY_W] <= stepKey0;
         if (ROUNDS_PER_CYCLE == 2) begin
            roundKeys[AES_KEY_W*(AES_NR - 1 - int'(counter)) +: AES_KEY_W] <= stepKey1;
            lastKey <= stepKey1;
            rcon    <= xtime(xtime(rcon));
         end else begin
            lastKey <= stepKey0;
            rcon    <= xtime(rcon);
         end
         counter <= counter + 4'(ROUNDS_PER_CYCLE);
      end
   end

endmodule

// File: tb/tb_aes128_key_schedule_seq.sv
// Directed bench for aes128_key_schedule_seq (one- and two-rounds-per-cycle instances).
module tb_aes128_key_schedule_seq;

   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] FIPS_R2  = 128'hf2c295f27a96b9435935807a7359f67f;
   localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
   localparam logic [127:0] ZERO_R2  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
   localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [127:0]  keyIn, keyIn2;
   logic          keyValid, keyValid2;
   logic          keyReady, keyReady2;
   logic [1407:0] roundKeys, roundKeys2;
   logic          keysValid, keysValid2;
   logic          zeroize;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   aes128_key_schedule_seq #(.ROUNDS_PER_CYCLE(1)) dut (
      .clk(clk),
      .rst_n(rst_n),
`ifdef AES_KEY_SCHED_ZEROIZE_EN
      .zeroize(zeroize),
`endif
      .key_in(keyIn),
      .key_valid(keyValid),
      .key_ready(keyReady),
      .round_keys(roundKeys),
      .keys_valid(keysValid)
   );

   aes128_key_schedule_seq #(.ROUNDS_PER_CYCLE(2)) dut2 (
      .clk(clk),
      .rst_n(rst_n),
`ifdef AES_KEY_SCHED_ZEROIZE_EN
      .zeroize(1'b0),
`endif
      .key_in(keyIn2),
      .key_valid(keyValid2),
      .key_ready(keyReady2),
      .round_keys(roundKeys2),
      .keys_valid(keysValid2)
   );

   task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [127:0] rkOf(input logic [1407:0] bus, input int r);
      return bus[128*(10-r) +: 128];
   endfunction

   initial begin
      rst_n     = 1'b0;
      keyIn     = '0;
      keyValid  = 1'b0;
      keyIn2    = '0;
      keyValid2 = 1'b0;
      zeroize   = 1'b0;
      tick(2);
      check("reset_round_keys", 128'(|roundKeys), 128'd0);
      check("reset_keys_valid", 128'(keysValid), 128'd0);
      check("reset_key_ready", 128'(keyReady), 128'd1);
      rst_n = 1'b1;
      tick(1);

      // FIPS-197 key, held for a single cycle
      keyIn    = FIPS_KEY;
      keyValid = 1'b1;
      check("fips_ready_before", 128'(keyReady), 128'd1);
      tick(1);
      keyValid = 1'b0;
      check("fips_ready_expand", 128'(keyReady), 128'd0);
      check("fips_rk0_early", rkOf(roundKeys, 0), FIPS_KEY);
      tick(9);
      check("fips_valid_edge9", 128'(keysValid), 128'd0);
      tick(1);
      check("fips_valid_edge10", 128'(keysValid), 128'd1);
      check("fips_rk0", rkOf(roundKeys, 0), FIPS_KEY);
      check("fips_rk1", rkOf(roundKeys, 1), FIPS_R1);
      check("fips_rk2", rkOf(roundKeys, 2), FIPS_R2);
      check("fips_rk10", rkOf(roundKeys, 10), FIPS_R10);
      check("fips_ready_done", 128'(keyReady), 128'd1);

      // All-zero key accepted from DONE; the FIPS key is then held throughout EXPAND
      keyIn    = '0;
      keyValid = 1'b1;
      tick(1);
      check("zero_accept_valid", 128'(keysValid), 128'd0);
      keyIn = FIPS_KEY;
      tick(5);
      check("second_ignored_ready", 128'(keyReady), 128'd0);
      check("second_ignored_rk0", rkOf(roundKeys, 0), 128'd0);
      tick(4);
      check("zero_valid_edge9", 128'(keysValid), 128'd0);
      tick(1);
      check("zero_valid_edge10", 128'(keysValid), 128'd1);
      check("zero_rk1", rkOf(roundKeys, 1), ZERO_R1);
      check("zero_rk2", rkOf(roundKeys, 2), ZERO_R2);
      check("zero_rk10", rkOf(roundKeys, 10), ZERO_R10);
      tick(1);
      check("second_accept_valid", 128'(keysValid), 128'd0);
      check("second_accept_rk0", rkOf(roundKeys, 0), FIPS_KEY);
      keyValid = 1'b0;
      tick(9);
      check("second_valid_edge9", 128'(keysValid), 128'd0);
      tick(1);
      check("second_valid_edge10", 128'(keysValid), 128'd1);
      check("second_rk10", rkOf(roundKeys, 10), FIPS_R10);

      // Reset pulsed in the middle of an expansion
      keyIn    = '0;
      keyValid = 1'b1;
      tick(1);
      keyValid = 1'b0;
      tick(4);
      #2 rst_n = 1'b0;
      #1;
      check("abort_round_keys", 128'(|roundKeys), 128'd0);
      check("abort_keys_valid", 128'(keysValid), 128'd0);
      check("abort_key_ready", 128'(keyReady), 128'd1);
      tick(1);
      rst_n = 1'b1;
      #1;
      check("abort_ready_release", 128'(keyReady), 128'd1);
      tick(1);
      check("abort_no_valid", 128'(keysValid), 128'd0);
      keyIn    = FIPS_KEY;
      keyValid = 1'b1;
      tick(1);
      keyValid = 1'b0;
      tick(9);
      check("restart_valid_edge9", 128'(keysValid), 128'd0);
      tick(1);
      check("restart_valid_edge10", 128'(keysValid), 128'd1);
      check("restart_rk1", rkOf(roundKeys, 1), FIPS_R1);
      check("restart_rk10", rkOf(roundKeys, 10), FIPS_R10);

      // Two rounds per cycle: all-zero key completes in five edges
      keyIn2    = '0;
      keyValid2 = 1'b1;
      check("rpc2_ready_before", 128'(keyReady2), 128'd1);
      tick(1);
      keyValid2 = 1'b0;
      check("rpc2_ready_expand", 128'(keyReady2), 128'd0);
      tick(4);
      check("rpc2_valid_edge4", 128'(keysValid2), 128'd0);
      tick(1);
      check("rpc2_valid_edge5", 128'(keysValid2), 128'd1);
      check("rpc2_rk0", rkOf(roundKeys2, 0), 128'd0);
      check("rpc2_rk1", rkOf(roundKeys2, 1), ZERO_R1);
      check("rpc2_rk2", rkOf(roundKeys2, 2), ZERO_R2);
      check("rpc2_rk10", rkOf(roundKeys2, 10), ZERO_R10);

`ifdef AES_KEY_SCHED_ZEROIZE_EN
      // Zeroize and a new key together while DONE: zeroize wins
      zeroize  = 1'b1;
      keyIn    = ZERO_R1;
      keyValid = 1'b1;
      #1;
      check("zeroize_ready_low", 128'(keyReady), 128'd0);
      tick(1);
      check("zeroize_round_keys", 128'(|roundKeys), 128'd0);
      check("zeroize_keys_valid", 128'(keysValid), 128'd0);
      zeroize  = 1'b0;
      keyValid = 1'b0;
      #1;
      check("zeroize_idle_ready", 128'(keyReady), 128'd1);
      tick(1);
      check("zeroize_not_accepted", 128'(|roundKeys), 128'd0);
      check("zeroize_still_idle", 128'(keyReady), 128'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
